// File: rtl/alu_issue_ctrl.sv
// ALU issue front end: decodes one request, drives the ALU for one cycle,
// captures the result and returns it over a valid/ready handshake.
module alu_issue_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_op,
    input  logic [5:0]       in_funct,
    input  logic [31:0]      in_rs,
    input  logic [31:0]      in_rt,
    input  logic [15:0]      in_imm,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_f,
    input  logic [31:0]      alu_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [31:0] dec_a, dec_b, sx, zx;
    logic [2:0]  dec_f;
    logic        dec_ill;

    assign sx = {{16{in_imm[15]}}, in_imm};
    assign zx = {16'h0000, in_imm};

    always_comb begin
        dec_a   = in_rs;
        dec_b   = in_rt;
        dec_f   = 3'b011;
        dec_ill = 1'b0;
        case (in_op)
            6'b000000: begin
                case (in_funct)
                    6'b100100: dec_f = 3'b000;
                    6'b100101: dec_f = 3'b001;
                    6'b100000: dec_f = 3'b010;
                    6'b100010: dec_f = 3'b110;
                    6'b101010: dec_f = 3'b111;
                    default:   dec_ill = 1'b1;
                endcase
            end
            6'b001000: begin dec_f = 3'b010; dec_b = sx; end
            6'b001100: begin dec_f = 3'b000; dec_b = zx; end
            6'b001101: begin dec_f = 3'b001; dec_b = zx; end
            6'b001010: begin dec_f = 3'b111; dec_b = sx; end
            6'b000100: dec_f = 3'b110;
            default:   dec_ill = 1'b1;
        endcase
        // Illegal ops present a fixed, harmless operand set to the ALU
        if (dec_ill) begin
            dec_a = 32'h0;
            dec_b = 32'h0;
            dec_f = 3'b011;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = EXEC;
            EXEC:    state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            alu_a       <= 32'h0;
            alu_b       <= 32'h0;
            alu_f       <= 3'b000;
            out_illegal <= 1'b0;
            out_result  <= 32'h0;
            out_zero    <= 1'b0;
            op_count    <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a       <= dec_a;
                        alu_b       <= dec_b;
                        alu_f       <= dec_f;
                        out_illegal <= dec_ill;
                    end
                end
                EXEC: begin
                    out_result <= out_illegal ? 32'h0 : alu_y;
                    out_zero   <= out_illegal || (alu_y == 32'h0);
                end
                DONE: begin
                    if (out_ready) op_count <= op_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached;
// a 2-bit counter exercises wrap-around.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [5:0]  in_funct;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [15:0] in_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;
    logic [1:0]  op_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_cnt = 2'd0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct(in_funct),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_illegal(out_illegal), .op_count(op_count)
    );

    // Reference ALU; code 011 returns junk so result forcing is visible
    always_comb begin
        alu_y = 32'hDEADBEEF;
        case (alu_f)
            3'b000: alu_y = alu_a & alu_b;
            3'b001: alu_y = alu_a | alu_b;
            3'b010: alu_y = alu_a + alu_b;
            3'b110: alu_y = alu_a - alu_b;
            3'b111: alu_y = {31'h0, $signed(alu_a) < $signed(alu_b)};
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, follow it to DONE, optionally hold back-pressure
    task automatic txn(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm,
                       input logic [31:0] ea, input logic [31:0] eb,
                       input logic [2:0] ef, input logic [31:0] er,
                       input logic ez, input logic ei, input int stall);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op = op; in_funct = fn;
        in_rs = rs; in_rt = rt; in_imm = imm;
        tick();
        in_valid = 1'b0;
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_f", 32'(alu_f), 32'(ef));
        check("exec_in_ready", 32'(in_ready), 32'd0);
        check("exec_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_result", out_result, er);
        check("out_zero", 32'(out_zero), 32'(ez));
        check("out_illegal", 32'(out_illegal), 32'(ei));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_op = 6'b000000; in_funct = 6'b100000;
            in_rs = 32'h55; in_rt = 32'h66;
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result", out_result, er);
            check("bp_zero", 32'(out_zero), 32'(ez));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_alu_a", alu_a, ea);
            check("bp_count", 32'(op_count), 32'(exp_cnt));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
        check("op_count", 32'(op_count), 32'(exp_cnt));
        check("done_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_funct = '0; in_rs = '0; in_rt = '0; in_imm = '0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_f", 32'(alu_f), 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Reset while a result is pending in DONE
        in_valid = 1'b1; in_op = 6'b000000; in_funct = 6'b100000;
        in_rs = 32'd3; in_rt = 32'd4;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_result", out_result, 32'd7);
        reset = 1'b1;
        tick();
        check("rst_done_valid", 32'(out_valid), 32'd0);
        check("rst_done_count", 32'(op_count), 32'd0);
        check("rst_done_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_rel_ready", 32'(in_ready), 32'd1);

        // R-type sub 5-5 -> zero
        txn(6'b000000, 6'b100010, 32'd5, 32'd5, 16'h0,
            32'd5, 32'd5, 3'b110, 32'd0, 1'b1, 1'b0, 0);
        // addi with sign extension
        txn(6'b001000, 6'b0, 32'h10, 32'h0, 16'hFFFF,
            32'h10, 32'hFFFFFFFF, 3'b010, 32'h0000000F, 1'b0, 1'b0, 0);
        // andi with zero extension
        txn(6'b001100, 6'b0, 32'h10, 32'h0, 16'hFFFF,
            32'h10, 32'h0000FFFF, 3'b000, 32'h00000010, 1'b0, 1'b0, 0);
        // Illegal opcode; count wraps 3 -> 0 here
        txn(6'b111111, 6'b0, 32'h1234, 32'h5678, 16'h1,
            32'h0, 32'h0, 3'b011, 32'h0, 1'b1, 1'b1, 0);
        // beq taken, with 10 cycles of back-pressure
        txn(6'b000100, 6'b0, 32'd7, 32'd7, 16'h0,
            32'd7, 32'd7, 3'b110, 32'd0, 1'b1, 1'b0, 10);
        // slt signed -1 < 1
        txn(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1, 16'h0,
            32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0, 0);
        // ori zero extension
        txn(6'b001101, 6'b0, 32'hF0000000, 32'h0, 16'h8001,
            32'hF0000000, 32'h00008001, 3'b001, 32'hF0008001, 1'b0, 1'b0, 0);
        // R-type unknown funct
        txn(6'b000000, 6'b111111, 32'd9, 32'd9, 16'h0,
            32'h0, 32'h0, 3'b011, 32'h0, 1'b1, 1'b1, 0);
        // slti with negative immediate: 2 < -2 is false
        txn(6'b001010, 6'b0, 32'd2, 32'h0, 16'hFFFE,
            32'd2, 32'hFFFFFFFE, 3'b111, 32'd0, 1'b1, 1'b0, 0);

        // out_ready while idle must not count
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_ready_count", 32'(op_count), 32'(exp_cnt));
        check("idle_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
